// File: rtl/bcd_tick_counter.sv
// -----------------------------------------------------------------------------
// bcd_tick_counter
//   Single BCD digit counter for the seven-segment decoder. A prescaler divides
//   the fabric clock down to a TICK_HZ strobe. The digit moves up or down once
//   per strobe. A debounced push button cycles STOP -> RUN -> HOLD -> RUN.
//   carry pulses on every wrap, so a second instance can be chained as the next
//   digit.
//
// Ports
//   clk       in   fabric clock; all logic runs on its rising edge
//   rst       in   synchronous active-high reset
//   btn_run   in   raw asynchronous push button, active-high
//   up_down   in   1 = count up, 0 = count down (sampled in the tick cycle)
//   load      in   one-cycle load request; forces STOP
//   load_val  in   value to load, clamped to MAX_DIGIT
//   digit     out  current count 0..MAX_DIGIT
//   tick      out  one-cycle strobe every DIV cycles while running
//   carry     out  one-cycle wrap pulse, coincident with the wrapped digit
//   running   out  high while in RUN
// -----------------------------------------------------------------------------
module bcd_tick_counter #(
    parameter int CLK_HZ          = 20_000_000,
    parameter int TICK_HZ         = 1,
    parameter int DEBOUNCE_CYCLES = 200_000,
    parameter int MAX_DIGIT       = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       up_down,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] digit,
    output logic       tick,
    output logic       carry,
    output logic       running
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]     MAX_VAL    = 4'(MAX_DIGIT);

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Button synchronizer. fill_reg marks when the synchronizer holds real
    // samples again after reset, so its cleared contents are not mistaken
    // for a released button.
    // ------------------------------------------------------------------
    logic [1:0] sync_reg;
    logic [1:0] fill_reg;
    logic       synced;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
            fill_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[0], btn_run};
            fill_reg <= {fill_reg[0], 1'b1};
        end
    end

    assign synced = sync_reg[1];

    // ------------------------------------------------------------------
    // Debouncer: the level follows the synced button only after it has
    // disagreed for DEBOUNCE_CYCLES consecutive cycles.
    // arm_reg blocks presses until the button has been seen released after
    // reset, so a button held through reset has to be re-pressed.
    // ------------------------------------------------------------------
    logic [DBW-1:0] db_cnt_reg;
    logic           db_level_reg;
    logic           db_prev_reg;
    logic           arm_reg;
    logic           press;

    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_reg   <= '0;
            db_level_reg <= 1'b0;
            db_prev_reg  <= 1'b0;
            arm_reg      <= 1'b0;
        end else begin
            db_prev_reg <= db_level_reg;
            arm_reg     <= arm_reg | (fill_reg[1] & ~synced);
            if (synced != db_level_reg) begin
                if (db_cnt_reg == DB_LAST) begin
                    db_level_reg <= synced;
                    db_cnt_reg   <= '0;
                end else begin
                    db_cnt_reg <= db_cnt_reg + 1'b1;
                end
            end else begin
                db_cnt_reg <= '0;
            end
        end
    end

    // Rising debounced edge only; release produces nothing.
    assign press = db_level_reg & ~db_prev_reg & arm_reg;

    // ------------------------------------------------------------------
    // State, prescaler, digit
    // ------------------------------------------------------------------
    state_t        state_reg, state_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [3:0]    digit_reg, digit_next;
    logic          carry_reg, carry_next;
    logic          tick_int;

    assign tick_int = (state_reg == RUN) && (presc_reg == PRESC_LAST);

    // load beats press; a press in a tick cycle lets the count through and
    // changes state on the same edge.
    always_comb begin
        state_next = state_reg;
        if (load) begin
            state_next = STOP;
        end else if (press) begin
            case (state_reg)
                STOP:    state_next = RUN;
                RUN:     state_next = HOLD;
                HOLD:    state_next = RUN;
                default: state_next = STOP;
            endcase
        end
    end

    // HOLD freezes the phase so a resume continues the interrupted period.
    always_comb begin
        presc_next = presc_reg;
        if (load) begin
            presc_next = '0;
        end else begin
            case (state_reg)
                RUN:     presc_next = tick_int ? '0 : presc_reg + 1'b1;
                HOLD:    presc_next = presc_reg;
                default: presc_next = '0;
            endcase
        end
    end

    always_comb begin
        digit_next = digit_reg;
        carry_next = 1'b0;
        if (load) begin
            digit_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (tick_int) begin
            if (up_down) begin
                if (digit_reg == MAX_VAL) begin
                    digit_next = 4'd0;
                    carry_next = 1'b1;
                end else begin
                    digit_next = digit_reg + 4'd1;
                end
            end else begin
                if (digit_reg == 4'd0) begin
                    digit_next = MAX_VAL;
                    carry_next = 1'b1;
                end else begin
                    digit_next = digit_reg - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= STOP;
            presc_reg <= '0;
            digit_reg <= 4'd0;
            carry_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            presc_reg <= presc_next;
            digit_reg <= digit_next;
            carry_reg <= carry_next;
        end
    end

    assign digit   = digit_reg;
    assign tick    = tick_int;
    assign carry   = carry_reg;
    assign running = (state_reg == RUN);

endmodule

// File: tb/tb_bcd_tick_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_tick_counter
//   Scenario tasks for bcd_tick_counter with DIV=10 and a 4-cycle debounce.
//   A behavioural model advances on every clock edge; each task compares the
//   DUT outputs against it and against fixed scenario expectations.
// -----------------------------------------------------------------------------
module tb_bcd_tick_counter;

    localparam int CLK_HZ  = 100;
    localparam int TICK_HZ = 10;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int DB      = 4;
    localparam int MAXD    = 9;

    localparam int ST_STOP = 0;
    localparam int ST_RUN  = 1;
    localparam int ST_HOLD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_run = 1'b0;
    logic       up_down = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] digit;
    logic       tick;
    logic       carry;
    logic       running;

    int checks = 0;
    int errors = 0;
    logic [6:0] obs;
    logic [6:0] exp_v;

    bcd_tick_counter #(
        .CLK_HZ(CLK_HZ),
        .TICK_HZ(TICK_HZ),
        .DEBOUNCE_CYCLES(DB),
        .MAX_DIGIT(MAXD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_run(btn_run),
        .up_down(up_down),
        .load(load),
        .load_val(load_val),
        .digit(digit),
        .tick(tick),
        .carry(carry),
        .running(running)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int m_digit = 0;
    int m_phase = 0;       // RUN cycles elapsed in the current period
    int m_state = ST_STOP;
    int m_run   = 0;       // consecutive cycles synced button != debounced
    int m_fill  = 0;       // button samples taken since reset
    bit m_carry = 0;
    bit m_level = 0;
    bit m_rose  = 0;
    bit m_armed = 0;
    bit m_tick  = 0;
    bit m_raw0  = 0;       // button sampled at the last edge
    bit m_raw1  = 0;       // button sampled one edge earlier

    function automatic int clamp(input int v);
        return (v > MAXD) ? MAXD : v;
    endfunction

    task automatic model_step();
        bit tk;
        bit pr;
        bit syn;
        if (rst) begin
            m_digit = 0; m_phase = 0; m_state = ST_STOP; m_carry = 0;
            m_level = 0; m_rose = 0; m_armed = 0; m_run = 0; m_fill = 0;
            m_raw0 = 0; m_raw1 = 0;
        end else begin
            tk  = (m_state == ST_RUN) && (m_phase == DIV - 1);
            pr  = m_rose && m_armed;
            syn = m_raw1;
            // digit
            if (load) begin
                m_digit = clamp(int'(load_val));
                m_carry = 0;
            end else if (tk) begin
                if (up_down) begin
                    m_carry = (m_digit == MAXD);
                    m_digit = (m_digit + 1) % (MAXD + 1);
                end else begin
                    m_carry = (m_digit == 0);
                    m_digit = (m_digit + MAXD) % (MAXD + 1);
                end
            end else begin
                m_carry = 0;
            end
            // prescaler phase
            if (load) m_phase = 0;
            else if (m_state == ST_RUN) m_phase = (m_phase + 1) % DIV;
            else if (m_state == ST_STOP) m_phase = 0;
            // state
            if (load) m_state = ST_STOP;
            else if (pr) m_state = (m_state == ST_RUN) ? ST_HOLD : ST_RUN;
            // button
            if (m_fill >= 2 && !syn) m_armed = 1;
            if (syn != m_level) begin
                m_run++;
                if (m_run == DB) begin
                    m_level = !m_level;
                    m_run = 0;
                    m_rose = m_level;
                end else begin
                    m_rose = 0;
                end
            end else begin
                m_run = 0;
                m_rose = 0;
            end
            m_raw1 = m_raw0;
            m_raw0 = btn_run;
            if (m_fill < 2) m_fill++;
        end
        m_tick = (m_state == ST_RUN) && (m_phase == DIV - 1);
    endtask

    function automatic logic [6:0] model_vec();
        return {4'(m_digit), m_carry, m_tick, (m_state == ST_RUN)};
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        obs   = {digit, carry, tick, running};
        exp_v = model_vec();
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        btn_run = 1'($urandom);
        up_down = 1'($urandom);
        load = 1'b1;
        load_val = 4'($urandom);
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (obs !== 7'b0) begin
                errors++;
                $display("FAIL reset_outputs: got %b required %b", obs, 7'b0);
            end
        end
        rst = 1'b0; btn_run = 1'b0; load = 1'b0; up_down = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: got %b required %b", i, obs, exp_v);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_count_up();
        int ticks = 0;
        int carries = 0;
        up_down = 1'b1;
        for (int i = 0; i < 120; i++) begin
            btn_run = (i < 8);
            cycle();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL count_up cyc %0d: got %b required %b", i, obs, exp_v);
            end
            if (tick) ticks++;
            if (carry) begin
                carries++;
                checks++;
                if (digit !== 4'd0) begin
                    errors++;
                    $display("FAIL count_up_carry_digit: got %0d required 0", digit);
                end
            end
            if (i == 5 || i == 6) begin
                checks++;
                if (running !== 1'(i == 6)) begin
                    errors++;
                    $display("FAIL press_latency cyc %0d: running %b required %b", i, running, 1'(i == 6));
                end
            end
        end
        checks++;
        if (ticks != 11) begin
            errors++;
            $display("FAIL count_up_ticks: got %0d required 11", ticks);
        end
        checks++;
        if (carries != 1) begin
            errors++;
            $display("FAIL count_up_carries: got %0d required 1", carries);
        end
        checks++;
        if (digit !== 4'd1) begin
            errors++;
            $display("FAIL count_up_final: got %0d required 1", digit);
        end
        $display("test_count_up done: ticks=%0d carries=%0d", ticks, carries);
    endtask

    task automatic test_count_down();
        int n = 0;
        bit was_tick;
        load = 1'b1; load_val = 4'd0;
        cycle();
        load = 1'b0;
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL down_load: got %b required %b", obs, exp_v);
        end
        for (int i = 0; i < 45; i++) begin
            btn_run = (i < 8);
            // Only the tick-cycle value of up_down may matter.
            up_down = m_tick ? 1'b0 : 1'($urandom);
            was_tick = m_tick;
            cycle();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL count_down cyc %0d: got %b required %b", i, obs, exp_v);
            end
            if (was_tick) begin
                n++;
                if (n == 1) begin
                    checks++;
                    if ({digit, carry} !== {4'd9, 1'b1}) begin
                        errors++;
                        $display("FAIL down_wrap: got d=%0d c=%b required d=9 c=1", digit, carry);
                    end
                end else if (n == 2) begin
                    checks++;
                    if ({digit, carry} !== {4'd8, 1'b0}) begin
                        errors++;
                        $display("FAIL down_step: got d=%0d c=%b required d=8 c=0", digit, carry);
                    end
                end
            end
        end
        checks++;
        if (n < 2) begin
            errors++;
            $display("FAIL down_tick_budget: got %0d ticks required >=2", n);
        end
        $display("test_count_down done: ticks=%0d", n);
    endtask

    task automatic test_button();
        int len;
        int ticks = 0;
        len = $urandom_range(1, DB - 1);
        for (int i = 0; i < 20; i++) begin
            btn_run = (i < len);
            up_down = 1'($urandom);
            cycle();
            checks++;
            if (obs !== exp_v || running !== 1'b1) begin
                errors++;
                $display("FAIL glitch len %0d cyc %0d: got %b required %b running=1", len, i, obs, exp_v);
            end
        end
        len = $urandom_range(DB + 1, 10);
        for (int i = 0; i < 25; i++) begin
            btn_run = (i < len);
            up_down = 1'($urandom);
            cycle();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL hold_press cyc %0d: got %b required %b", i, obs, exp_v);
            end
        end
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL hold_state: running %b required 0", running);
        end
        for (int i = 0; i < 25; i++) begin
            cycle();
            if (tick) ticks++;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL hold_idle cyc %0d: got %b required %b", i, obs, exp_v);
            end
        end
        checks++;
        if (ticks != 0) begin
            errors++;
            $display("FAIL hold_ticks: got %0d required 0", ticks);
        end
        len = $urandom_range(DB + 1, 10);
        for (int i = 0; i < 40; i++) begin
            btn_run = (i < len);
            up_down = 1'($urandom);
            cycle();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL resume cyc %0d: got %b required %b", i, obs, exp_v);
            end
        end
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL resume_state: running %b required 1", running);
        end
        $display("test_button done");
    endtask

    task automatic test_load_on_tick();
        bit found = 0;
        int v;
        int ticks = 0;
        up_down = 1'b1;
        for (int i = 0; i < DIV + 2 && !found; i++) begin
            if (m_tick) begin
                v = $urandom_range(10, 15);
                load = 1'b1; load_val = 4'(v);
                cycle();
                load = 1'b0;
                found = 1;
                checks++;
                if (obs !== 7'b1001000) begin
                    errors++;
                    $display("FAIL load_on_tick val %0d: got %b required %b", v, obs, 7'b1001000);
                end
            end else begin
                cycle();
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL load_wait cyc %0d: got %b required %b", i, obs, exp_v);
                end
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL load_tick_timeout: got no tick required one within %0d cycles", DIV + 2);
        end
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (tick) ticks++;
        end
        checks++;
        if (ticks != 0 || obs !== exp_v) begin
            errors++;
            $display("FAIL stop_after_load: ticks %0d vec %b required 0 ticks vec %b", ticks, obs, exp_v);
        end
        for (int k = 0; k < 6; k++) begin
            v = $urandom_range(0, 15);
            load = 1'b1; load_val = 4'(v);
            cycle();
            load = 1'b0;
            checks++;
            if (digit !== 4'(clamp(v)) || obs !== exp_v) begin
                errors++;
                $display("FAIL load_clamp val %0d: got %0d required %0d", v, digit, clamp(v));
            end
        end
        $display("test_load_on_tick done");
    endtask

    task automatic test_reset_mid();
        load = 1'b1; load_val = 4'd4; up_down = 1'b1;
        cycle();
        load = 1'b0;
        for (int i = 0; i < 35; i++) begin
            btn_run = (i < 8) || (i >= 16 && i < 24);
            cycle();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_mid_setup cyc %0d: got %b required %b", i, obs, exp_v);
            end
        end
        checks++;
        if (digit !== 4'd5 || running !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_hold: got d=%0d run=%b required d=5 run=0", digit, running);
        end
        rst = 1'b1; btn_run = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL reset_mid_clear: got %b required %b", obs, 7'b0);
        end
        for (int i = 0; i < 20; i++) begin
            cycle();
            checks++;
            if (running !== 1'b0 || obs !== exp_v) begin
                errors++;
                $display("FAIL held_through_reset cyc %0d: got %b required %b", i, obs, exp_v);
            end
        end
        for (int i = 0; i < 30; i++) begin
            btn_run = (i >= 10 && i < 18);
            cycle();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL repress cyc %0d: got %b required %b", i, obs, exp_v);
            end
        end
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL repress_state: running %b required 1", running);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_load_press();
        bit found = 0;
        bit now;
        int v = 0;
        int ticks = 0;
        load = 1'b1; load_val = 4'd3;
        cycle();
        load = 1'b0;
        for (int i = 0; i < 20; i++) begin
            btn_run = (i < 8);
            now = m_rose && m_armed;
            if (now) begin
                v = $urandom_range(0, 15);
                load_val = 4'(v);
            end
            load = now;
            cycle();
            load = 1'b0;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL load_press cyc %0d: got %b required %b", i, obs, exp_v);
            end
            if (now) begin
                found = 1;
                checks++;
                if (running !== 1'b0 || digit !== 4'(clamp(v))) begin
                    errors++;
                    $display("FAIL load_beats_press: got run=%b d=%0d required run=0 d=%0d", running, digit, clamp(v));
                end
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL load_press_timeout: got no press cycle required one within 20 cycles");
        end
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (tick) ticks++;
        end
        checks++;
        if (ticks != 0 || running !== 1'b0) begin
            errors++;
            $display("FAIL load_press_stop: ticks %0d run %b required 0 ticks run 0", ticks, running);
        end
        $display("test_load_press done");
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_button();
        test_load_on_tick();
        test_reset_mid();
        test_load_press();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
